// File: rtl/conv_pkg.sv
// Shared definitions for the post-convolution stages: default widths, the
// largest legal matrix side, the data word type and the pooling FSM encoding.
package conv_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int MAX_DIM        = 64;

  typedef logic signed [15:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/relu_maxpool2x2_if.sv
// Run/busy handshake plus scratchpad read and output SRAM write ports of the
// ReLU + 2x2 max-pool stage. 'slave' is the pooling block's view.
interface relu_maxpool2x2_if
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  run;
  logic [6:0]            dim;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] scratchpad_sram_read_address;
  logic [DATA_WIDTH-1:0] scratchpad_sram_read_data;
  logic                  output_sram_write_enable;
  logic [ADDR_WIDTH-1:0] output_sram_write_addresss;
  logic [DATA_WIDTH-1:0] output_sram_write_data;

  modport master (
    output run,
    output dim,
    input  busy,
    input  scratchpad_sram_read_address,
    output scratchpad_sram_read_data,
    input  output_sram_write_enable,
    input  output_sram_write_addresss,
    input  output_sram_write_data
  );

  modport slave (
    input  run,
    input  dim,
    output busy,
    output scratchpad_sram_read_address,
    input  scratchpad_sram_read_data,
    output output_sram_write_enable,
    output output_sram_write_addresss,
    output output_sram_write_data
  );

endinterface

// File: rtl/pool_addr_gen.sv
// Window and output address counters for 2x2 stride-2 pooling. Row bases step
// by 2N so no multiplier is needed; the output address simply counts up.
module pool_addr_gen #(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] IN_BASE    = '0,
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_advance,
  input  logic [6:0]            i_dim,
  output logic [ADDR_WIDTH-1:0] o_win0,
  output logic [ADDR_WIDTH-1:0] o_win1,
  output logic [ADDR_WIDTH-1:0] o_win2,
  output logic [ADDR_WIDTH-1:0] o_win3,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [6:0]            r_row;
  logic [6:0]            r_col;

  logic [ADDR_WIDTH-1:0] w_n;
  logic [ADDR_WIDTH-1:0] w_col;
  logic                  w_col_wrap;
  logic                  w_row_wrap;

  assign w_n   = ADDR_WIDTH'(i_dim);
  assign w_col = ADDR_WIDTH'(r_col);

  assign o_win0    = r_row_base + w_col;
  assign o_win1    = r_row_base + w_col + 1'b1;
  assign o_win2    = r_row_base + w_n + w_col;
  assign o_win3    = r_row_base + w_n + w_col + 1'b1;
  assign o_wr_addr = r_out_addr;

  // c+2 > N-2 rewritten as c+4 > N so odd N drops the trailing row/column
  assign w_col_wrap = ({1'b0, r_col} + 8'd4) > {1'b0, i_dim};
  assign w_row_wrap = ({1'b0, r_row} + 8'd4) > {1'b0, i_dim};
  assign o_last     = w_col_wrap && w_row_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_base <= '0;
      r_out_addr <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else if (i_start) begin
      r_row_base <= IN_BASE;
      r_out_addr <= OUT_BASE;
      r_row      <= '0;
      r_col      <= '0;
    end else if (i_advance) begin
      r_out_addr <= r_out_addr + 1'b1;
      if (w_col_wrap) begin
        r_col      <= '0;
        r_row      <= r_row + 7'd2;
        r_row_base <= r_row_base + (w_n << 1);
      end else begin
        r_col      <= r_col + 7'd2;
      end
    end
  end

endmodule

// File: rtl/relu_maxpool2x2.sv
// ReLU + 2x2 stride-2 max-pool: reads an NxN signed matrix from scratchpad,
// writes floor(N/2)^2 pooled words to output SRAM, one every 6 cycles.
module relu_maxpool2x2
  import conv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] IN_BASE    = '0,
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE   = '0
) (
  input logic              clk,
  input logic              reset,
  relu_maxpool2x2_if.slave bus
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_READ  = ST_READ;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_WRITE = ST_WRITE;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]                   r_state;
  logic [6:0]                   r_dim;
  logic [1:0]                   r_k;
  logic                         r_busy;
  logic                         r_last;
  logic                         r_we;
  logic [ADDR_WIDTH-1:0]        r_rd_addr;
  logic [ADDR_WIDTH-1:0]        r_wr_addr;
  logic signed [DATA_WIDTH-1:0] r_mx;
  logic signed [DATA_WIDTH-1:0] r_wdata;

  logic [ADDR_WIDTH-1:0]        w_win0;
  logic [ADDR_WIDTH-1:0]        w_win1;
  logic [ADDR_WIDTH-1:0]        w_win2;
  logic [ADDR_WIDTH-1:0]        w_win3;
  logic [ADDR_WIDTH-1:0]        w_out_addr;
  logic [ADDR_WIDTH-1:0]        w_next_addr;
  logic                         w_last;
  logic                         w_start;
  logic                         w_advance;
  logic signed [DATA_WIDTH-1:0] w_rd_data;
  logic signed [DATA_WIDTH-1:0] w_fold;

  assign w_start   = (r_state == S_IDLE) && bus.run;
  assign w_advance = (r_state == S_DRAIN);
  assign w_rd_data = $signed(bus.scratchpad_sram_read_data);
  assign w_fold    = (w_rd_data > r_mx) ? w_rd_data : r_mx;

  pool_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IN_BASE    (IN_BASE),
    .OUT_BASE   (OUT_BASE)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_advance (w_advance),
    .i_dim     (r_dim),
    .o_win0    (w_win0),
    .o_win1    (w_win1),
    .o_win2    (w_win2),
    .o_win3    (w_win3),
    .o_wr_addr (w_out_addr),
    .o_last    (w_last)
  );

  always_comb begin
    w_next_addr = w_win3;
    case (r_k)
      2'd0:    w_next_addr = w_win1;
      2'd1:    w_next_addr = w_win2;
      default: w_next_addr = w_win3;
    endcase
  end

  // Read data lags its address by one cycle, so datum k is folded while READ
  // k+1 (or DRAIN for k=3) is on the bus; counters advance during DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dim     <= '0;
      r_k       <= '0;
      r_busy    <= 1'b0;
      r_last    <= 1'b0;
      r_we      <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_mx      <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.run) begin
            r_dim     <= bus.dim;
            r_k       <= '0;
            r_rd_addr <= IN_BASE;
            r_busy    <= 1'b1;
            r_state   <= (bus.dim < 7'd2) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (r_k == 2'd1) begin
            r_mx <= w_rd_data;
          end else if (r_k != 2'd0) begin
            r_mx <= w_fold;
          end
          if (r_k == 2'd3) begin
            r_state <= S_DRAIN;
          end else begin
            r_k       <= r_k + 2'd1;
            r_rd_addr <= w_next_addr;
          end
        end
        S_DRAIN: begin
          r_mx      <= w_fold;
          r_we      <= 1'b1;
          r_wr_addr <= w_out_addr;
          r_wdata   <= w_fold[DATA_WIDTH-1] ? '0 : w_fold;
          r_last    <= w_last;
          r_state   <= S_WRITE;
        end
        S_WRITE: begin
          r_we <= 1'b0;
          r_k  <= '0;
          if (r_last) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_rd_addr <= w_win0;
            r_state   <= S_READ;
          end
        end
        S_DONE: begin
          r_busy <= 1'b0;
          if (!bus.run) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy                         = r_busy;
  assign bus.scratchpad_sram_read_address = r_rd_addr;
  assign bus.output_sram_write_enable     = r_we;
  assign bus.output_sram_write_addresss   = r_wr_addr;
  assign bus.output_sram_write_data       = r_wdata;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench for relu_maxpool2x2 with behavioural 1-cycle scratchpad and
// output SRAM models; table vectors plus hand-written corner sequences.
module tb_relu_maxpool2x2;

  localparam logic [11:0] IN_B  = 12'h100;
  localparam logic [11:0] OUT_B = 12'h020;

  typedef struct {
    int                n;
    logic [15:0][15:0] din;
    logic [3:0][15:0]  dexp;
    int                nOut;
    int                expBusy;
  } vec_t;

  logic clk;
  logic reset;

  relu_maxpool2x2_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();

  relu_maxpool2x2 #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (16),
    .IN_BASE    (IN_B),
    .OUT_BASE   (OUT_B)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] scratch  [0:4095];
  logic [15:0] outMem   [0:4095];
  logic        readSeen [0:4095];
  logic [11:0] wrLog    [$];
  int          writeCount;
  int          tests;
  int          failures;
  vec_t        vecs     [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.scratchpad_sram_read_data <= scratch[bus.scratchpad_sram_read_address];
    if (bus.busy) readSeen[bus.scratchpad_sram_read_address] = 1'b1;
    if (bus.output_sram_write_enable) begin
      outMem[bus.output_sram_write_addresss] = bus.output_sram_write_data;
      wrLog.push_back(bus.output_sram_write_addresss);
      writeCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearTracking();
    for (int i = 0; i < 4096; i++) begin
      outMem[i]   = 16'hDEAD;
      readSeen[i] = 1'b0;
    end
    wrLog.delete();
    writeCount = 0;
  endtask

  // One-cycle run pulse; returns at the negedge of the first busy cycle.
  task automatic applyStimulus(input int n);
    @(negedge clk);
    bus.dim = 7'(n);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
  endtask

  task automatic waitForIdle(output int cycles);
    cycles = 0;
    for (int g = 0; g < 2000 && bus.busy; g++) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] val8(input int i, input int j);
    int t;
    t = (((i * 8 + j) * 37) % 251) - 100;
    return t[15:0];
  endfunction

  function automatic logic [15:0] pool8(input int pr, input int pc);
    logic signed [15:0] mx;
    logic signed [15:0] v;
    mx = $signed(val8(2 * pr, 2 * pc));
    for (int d = 1; d < 4; d++) begin
      v = $signed(val8(2 * pr + d / 2, 2 * pc + d % 2));
      if (v > mx) mx = v;
    end
    return (mx < 0) ? 16'h0000 : mx;
  endfunction

  initial begin
    int          cyc;
    int          busyCnt;
    int          seen;
    int          priorWrites;
    logic [11:0] logAddr;

    tests      = 0;
    failures   = 0;
    writeCount = 0;
    reset      = 1'b1;
    bus.run    = 1'b0;
    bus.dim    = '0;
    for (int i = 0; i < 4096; i++) scratch[i] = 16'h0000;
    clearTracking();

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    checkOutput("reset_we", 32'(bus.output_sram_write_enable), 32'h0);
    checkOutput("reset_rd_addr", 32'(bus.scratchpad_sram_read_address), 32'h0);
    checkOutput("reset_wr_addr", 32'(bus.output_sram_write_addresss), 32'h0);
    checkOutput("reset_wr_data", 32'(bus.output_sram_write_data), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0].n = 4; vecs[0].nOut = 4; vecs[0].expBusy = 24;
    for (int i = 0; i < 16; i++) vecs[0].din[i] = 16'(i + 1);
    vecs[0].dexp = {16'd16, 16'd14, 16'd8, 16'd6};

    vecs[1].n = 4; vecs[1].nOut = 4; vecs[1].expBusy = 24;
    for (int i = 0; i < 16; i++) vecs[1].din[i] = 16'hFFF0 + 16'(i);
    vecs[1].dexp = '0;

    vecs[2].n = 4; vecs[2].nOut = 4; vecs[2].expBusy = 24;
    vecs[2].din = {16'hFFFE, 16'hFFFF, 16'h0004, 16'h0005,
                   16'h8001, 16'h8000, 16'hFFFE, 16'h0010,
                   16'h8000, 16'h0003, 16'h0000, 16'hFFFF,
                   16'h0002, 16'h0001, 16'h7FFF, 16'h8000};
    vecs[2].dexp = {16'h0000, 16'h0010, 16'h0003, 16'h7FFF};

    vecs[3].n = 2; vecs[3].nOut = 1; vecs[3].expBusy = 6;
    vecs[3].din = '0;
    vecs[3].din[0] = 16'd3; vecs[3].din[1] = 16'd9;
    vecs[3].din[2] = 16'd2; vecs[3].din[3] = 16'd7;
    vecs[3].dexp = {16'h0, 16'h0, 16'h0, 16'd9};

    vecs[4].n = 4; vecs[4].nOut = 4; vecs[4].expBusy = 24;
    for (int i = 0; i < 16; i++) vecs[4].din[i] = 16'(16 - i);
    vecs[4].dexp = {16'd6, 16'd8, 16'd14, 16'd16};

    for (int v = 0; v < 5; v++) begin
      clearTracking();
      for (int i = 0; i < vecs[v].n * vecs[v].n; i++) scratch[IN_B + 12'(i)] = vecs[v].din[i];
      applyStimulus(vecs[v].n);
      waitForIdle(cyc);
      checkOutput($sformatf("vec%0d_busy_cycles", v), 32'(cyc), 32'(vecs[v].expBusy));
      checkOutput($sformatf("vec%0d_write_count", v), 32'(writeCount), 32'(vecs[v].nOut));
      for (int i = 0; i < vecs[v].nOut; i++) begin
        checkOutput($sformatf("vec%0d_out%0d", v, i), 32'(outMem[OUT_B + 12'(i)]), 32'(vecs[v].dexp[i]));
        logAddr = (i < wrLog.size()) ? wrLog[i] : 12'hFFF;
        checkOutput($sformatf("vec%0d_wr_addr%0d", v, i), 32'(logAddr), 32'(OUT_B + 12'(i)));
      end
      @(negedge clk);
    end

    // N=5: odd side drops row 4 / column 4, which hold the matrix maximum
    clearTracking();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) scratch[IN_B + 12'(i * 5 + j)] = 16'(i * 5 + j + 1);
    applyStimulus(5);
    waitForIdle(cyc);
    checkOutput("n5_busy_cycles", 32'(cyc), 32'd24);
    checkOutput("n5_write_count", 32'(writeCount), 32'd4);
    checkOutput("n5_out0", 32'(outMem[OUT_B + 12'd0]), 32'd7);
    checkOutput("n5_out1", 32'(outMem[OUT_B + 12'd1]), 32'd9);
    checkOutput("n5_out2", 32'(outMem[OUT_B + 12'd2]), 32'd17);
    checkOutput("n5_out3", 32'(outMem[OUT_B + 12'd3]), 32'd19);
    checkOutput("n5_out4_untouched", 32'(outMem[OUT_B + 12'd4]), 32'hDEAD);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (readSeen[IN_B + 12'(4 * 5 + k)]) seen++;
      if (k < 4 && readSeen[IN_B + 12'(k * 5 + 4)]) seen++;
    end
    checkOutput("n5_edge_reads", 32'(seen), 32'd0);

    // N=0 and N=1: a single busy cycle and no writes
    for (int nn = 0; nn < 2; nn++) begin
      clearTracking();
      applyStimulus(nn);
      waitForIdle(cyc);
      checkOutput($sformatf("n%0d_busy_cycles", nn), 32'(cyc), 32'd1);
      repeat (5) @(negedge clk);
      checkOutput($sformatf("n%0d_write_count", nn), 32'(writeCount), 32'd0);
      checkOutput($sformatf("n%0d_idle_busy", nn), 32'(bus.busy), 32'd0);
    end

    // Held run: exactly one pass until run is dropped and raised again
    clearTracking();
    scratch[IN_B + 12'd0] = 16'd1;
    scratch[IN_B + 12'd1] = 16'hFFFB;
    scratch[IN_B + 12'd2] = 16'd4;
    scratch[IN_B + 12'd3] = 16'd2;
    @(negedge clk);
    bus.dim = 7'd2;
    bus.run = 1'b1;
    busyCnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.busy) busyCnt++;
    end
    checkOutput("hold_busy_cycles", 32'(busyCnt), 32'd6);
    checkOutput("hold_write_count", 32'(writeCount), 32'd1);
    checkOutput("hold_out0", 32'(outMem[OUT_B]), 32'd4);
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("hold_idle_busy", 32'(bus.busy), 32'd0);
    applyStimulus(2);
    waitForIdle(cyc);
    checkOutput("rerun_busy_cycles", 32'(cyc), 32'd6);
    checkOutput("rerun_write_count", 32'(writeCount), 32'd2);
    logAddr = (wrLog.size() > 1) ? wrLog[1] : 12'hFFF;
    checkOutput("rerun_wr_addr", 32'(logAddr), 32'(OUT_B));

    // Reset during cycle 10 of an 8x8 pass, then a clean full pass
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) scratch[IN_B + 12'(i * 8 + j)] = val8(i, j);
    clearTracking();
    applyStimulus(8);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_we", 32'(bus.output_sram_write_enable), 32'd0);
    checkOutput("midreset_prior_writes_le1", 32'(writeCount <= 1), 32'd1);
    priorWrites = writeCount;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("midreset_no_late_write", 32'(writeCount), 32'(priorWrites));
    checkOutput("midreset_stays_idle", 32'(bus.busy), 32'd0);
    clearTracking();
    applyStimulus(8);
    waitForIdle(cyc);
    checkOutput("n8_busy_cycles", 32'(cyc), 32'd96);
    checkOutput("n8_write_count", 32'(writeCount), 32'd16);
    for (int pr = 0; pr < 4; pr++)
      for (int pc = 0; pc < 4; pc++)
        checkOutput($sformatf("n8_out_r%0d_c%0d", pr, pc),
                    32'(outMem[OUT_B + 12'(pr * 4 + pc)]), 32'(pool8(pr, pc)));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
